// File: rtl/jpeg_pkg.sv
// Shared JPEG block-ordering definitions.
//   BLK_N         : coefficients per 8x8 block.
//   raster_idx_t  : 6-bit raster index, 8*row + col.
//   ZZ_TO_RASTER  : raster index of zigzag position k. The encoder-side
//                   reorder stage uses the same table.
//   raster_lsb()  : bit offset of element (r,c) in a flat raster block word.
//                   Element (r,c) occupies [(8r+c)*w +: w].
package jpeg_pkg;

  localparam int BLK_N = 64;

  typedef logic [5:0] raster_idx_t;

  localparam raster_idx_t ZZ_TO_RASTER [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic int raster_lsb(input int r, input int c, input int w);
    return (8 * r + c) * w;
  endfunction

endpackage

// File: rtl/izigzag_bank.sv
// One 64-entry coefficient bank, written one raster slot at a time and read
// as a whole block.
//   clk, rst_n : clock, asynchronous active-low reset (contents clear to 0)
//   we         : write enable
//   waddr      : raster index (8r+c) to write
//   wdata      : coefficient to store
//   rdata      : whole bank, entry i at [i*DATA_W +: DATA_W]
module izigzag_bank
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [5:0]              waddr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [BLK_N*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [BLK_N];
  logic [DATA_W-1:0] mem_d [BLK_N];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < BLK_N; i++) begin : g_rd
    assign rdata[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: rtl/izigzag_block_assembler.sv
// Inverse zigzag block assembler. Coefficients arrive one per beat in zigzag
// order and are scattered into raster slots of one of two ping-pong banks;
// a completed bank is presented as one flat raster-order block.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : coefficient beat handshake
//   in_data             : coefficient at the current zigzag index
//   in_sop              : marks zigzag index 0 of a block
//   out_valid/out_ready : block handshake
//   out_block           : element (r,c) at [(8r+c)*DATA_W +: DATA_W]
//   err_sop             : one-cycle pulse when in_sop cut a partial block short
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both high; valid/data hold until that edge, and ready
// is derived from registered state only.
module izigzag_block_assembler
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_sop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK_N*DATA_W-1:0] out_block,
  output logic                    err_sop
);

  logic [5:0] k_q, k_d;
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  logic [1:0] full_q, full_d;
  logic       err_sop_q, err_sop_d;

  logic                    accept;
  logic                    drain;
  logic                    last_beat;
  logic [5:0]              eff_k;
  logic [5:0]              wr_addr;
  logic [BLK_N*DATA_W-1:0] bank_rd [2];

  assign in_ready  = !full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign out_block = bank_rd[rb_q];
  assign err_sop   = err_sop_q;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // An sop beat always lands at zigzag index 0, restarting the block.
  // Slots left over from a truncated block are rewritten before it completes.
  assign eff_k     = in_sop ? 6'd0 : k_q;
  assign wr_addr   = ZZ_TO_RASTER[eff_k];
  assign last_beat = accept && (eff_k == 6'd63);

  always_comb begin
    k_d       = k_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    full_d    = full_q;
    err_sop_d = 1'b0;

    if (accept) begin
      k_d       = eff_k + 6'd1;
      err_sop_d = in_sop && (k_q != 6'd0);
    end

    // Fill requires full[wb]==0 and drain requires full[rb]==1, so when both
    // happen in one cycle they always touch different banks.
    if (last_beat) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    if (drain) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      full_q    <= '0;
      err_sop_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      full_q    <= full_d;
      err_sop_q <= err_sop_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    izigzag_bank #(.DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && (wb_q == b[0])),
      .waddr (wr_addr),
      .wdata (in_data),
      .rdata (bank_rd[b])
    );
  end

endmodule

// File: tb/tb_izigzag_block_assembler.sv
module tb_izigzag_block_assembler;

  localparam int DATA_W = 8;
  localparam int BLK_W  = 64 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BLK_W-1:0]  out_block;
  logic              err_sop;

  izigzag_block_assembler #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .err_sop   (err_sop)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [BLK_W-1:0]  exp_q [$];    // completed blocks awaiting output
  logic [DATA_W:0]   beat_q [$];   // {sop, data} waiting to be sent
  int                zz [64];      // zigzag position -> raster index
  logic [BLK_W-1:0]  part;         // block under assembly (raster order)
  int                cnt = 0;      // beats in current block
  logic              exp_err = 1'b0;

  int ordy_mode = 1;   // 0: out_ready low, 1: high, 2: random
  int valid_pct = 100;
  int stall_cnt = 0;
  int err_cnt = 0;
  int drains = 0;

  task automatic check(input string tag, input logic [BLK_W-1:0] act,
                       input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Zigzag order from its definition: walk anti-diagonals s=r+c, going
  // down-left on odd s and up-right on even s.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz[k] = 8 * r + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz[k] = 8 * r + (s - r); k++; end
      end
    end
  endtask

  task automatic model_beat(input logic [DATA_W-1:0] d, input logic s);
    if (s && cnt != 0) exp_err = 1'b1;
    if (s) cnt = 0;
    part[zz[cnt]*DATA_W +: DATA_W] = d;
    cnt++;
    if (cnt == 64) begin
      exp_q.push_back(part);
      cnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    beat_q.delete();
    part = '0;
    cnt = 0;
    exp_err = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Entered and left at a falling edge: drive inputs, check registered
  // outputs against the model, account for the handshakes of the next edge.
  task automatic cycle();
    logic v, s, o;
    logic [DATA_W-1:0] d;
    v = 1'b0; s = 1'b0; d = '0;
    if (beat_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      v = 1'b1;
      {s, d} = beat_q[0];
    end
    case (ordy_mode)
      0:       o = 1'b0;
      1:       o = 1'b1;
      default: o = 1'($urandom_range(0, 1));
    endcase
    in_valid = v; in_sop = s; in_data = d; out_ready = o;

    check("in_ready", BLK_W'(in_ready), BLK_W'(exp_q.size() < 2));
    check("out_valid", BLK_W'(out_valid), BLK_W'(exp_q.size() > 0));
    check("err_sop", BLK_W'(err_sop), BLK_W'(exp_err));
    exp_err = 1'b0;
    if (!in_ready) stall_cnt++;
    if (err_sop) err_cnt++;

    if (out_valid && o) begin
      drains++;
      if (exp_q.size() > 0) check("out_block", out_block, exp_q.pop_front());
    end
    if (v && in_ready) begin
      void'(beat_q.pop_front());
      model_beat(d, s);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_block(input logic with_sop);
    logic [DATA_W-1:0] src [64];
    for (int i = 0; i < 64; i++) src[i] = DATA_W'($urandom);
    for (int k = 0; k < 64; k++) beat_q.push_back({with_sop && (k == 0), src[zz[k]]});
  endtask

  task automatic run_beats(input int budget);
    int n = 0;
    while (beat_q.size() > 0 && n < budget) begin cycle(); n++; end
    check("beat_timeout", BLK_W'(beat_q.size()), '0);
  endtask

  task automatic drain_all();
    int n = 0;
    ordy_mode = 1;
    while (exp_q.size() > 0 && n < 300) begin cycle(); n++; end
    check("drain_timeout", BLK_W'(exp_q.size()), '0);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    build_zz();
    model_reset();

    #12;
    check("rst_in_ready", BLK_W'(in_ready), BLK_W'(1));
    check("rst_out_valid", BLK_W'(out_valid), '0);
    check("rst_err_sop", BLK_W'(err_sop), '0);
    check("rst_out_block", out_block, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: coefficient value = zigzag index.
    ordy_mode = 1;
    for (int k = 0; k < 64; k++) beat_q.push_back({k == 0, DATA_W'(k)});
    run_beats(100);
    check("t1_out_valid", BLK_W'(out_valid), BLK_W'(1));
    check("t1_r0", BLK_W'(out_block[0*8 +: 8]), BLK_W'(0));
    check("t1_r8", BLK_W'(out_block[8*8 +: 8]), BLK_W'(2));
    check("t1_r7", BLK_W'(out_block[7*8 +: 8]), BLK_W'(28));
    check("t1_r56", BLK_W'(out_block[56*8 +: 8]), BLK_W'(35));
    check("t1_r55", BLK_W'(out_block[55*8 +: 8]), BLK_W'(61));
    check("t1_r63", BLK_W'(out_block[63*8 +: 8]), BLK_W'(63));
    drain_all();

    // T2: 10 random blocks back to back, no in_ready bubbles.
    stall_cnt = 0;
    base = drains;
    for (int b = 0; b < 10; b++) push_block(1'b1);
    run_beats(700);
    drain_all();
    check("t2_stalls", BLK_W'(stall_cnt), '0);
    check("t2_blocks", BLK_W'(drains - base), BLK_W'(10));

    // T3: backpressure, two blocks buffered.
    ordy_mode = 0;
    for (int b = 0; b < 3; b++) push_block(1'b1);
    for (int n = 0; n < 140; n++) cycle();
    check("t3_accepted", BLK_W'(beat_q.size()), BLK_W'(64));
    check("t3_in_ready", BLK_W'(in_ready), '0);
    ordy_mode = 1;
    cycle();
    check("t3_reassert", BLK_W'(in_ready), BLK_W'(1));
    run_beats(200);
    drain_all();

    // T4: sop truncates a partial block.
    err_cnt = 0;
    for (int i = 0; i < 20; i++) beat_q.push_back({i == 0, DATA_W'($urandom)});
    push_block(1'b1);
    run_beats(200);
    drain_all();
    check("t4_err_pulses", BLK_W'(err_cnt), BLK_W'(1));

    // T5: reset mid-block, then a block without sop must start at k=0.
    for (int i = 0; i < 30; i++) beat_q.push_back({i == 0, DATA_W'($urandom)});
    for (int n = 0; n < 30; n++) cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", BLK_W'(out_valid), '0);
    check("t5_rst_in_ready", BLK_W'(in_ready), BLK_W'(1));
    check("t5_rst_block", out_block, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push_block(1'b0);
    run_beats(100);
    drain_all();

    // T6: last beat of bank B lands on the edge that drains bank A.
    ordy_mode = 0;
    base = drains;
    push_block(1'b1);
    push_block(1'b1);
    while (beat_q.size() > 1) begin
      int n = 0;
      cycle();
      n++;
      if (n > 200) break;
    end
    check("t6_pending", BLK_W'(exp_q.size()), BLK_W'(1));
    ordy_mode = 1;
    cycle();
    check("t6_both_full", BLK_W'(exp_q.size()), BLK_W'(1));
    drain_all();
    check("t6_blocks", BLK_W'(drains - base), BLK_W'(2));

    // T7: random valid gaps and random out_ready.
    ordy_mode = 2;
    valid_pct = 70;
    for (int b = 0; b < 6; b++) push_block($urandom_range(0, 1) == 1);
    run_beats(2000);
    valid_pct = 100;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
